// File: rtl/alu_shift_pkg.sv
// Shared shifter definitions: op encodings and default geometry, common to the
// left and right shifters.
package alu_shift_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CNT_W = 4;

   typedef enum logic [1:0] {
      OP_ROR  = 2'b00,
      OP_SRL  = 2'b01,
      OP_SRA  = 2'b10,
      OP_PASS = 2'b11
   } shift_op_e;

endpackage

// File: rtl/barrel_shifter_right_pipe_if.sv
// Operand/result handshake bundle for the pipelined right shifter.
// master = operand producer / result consumer, slave = shifter.
interface barrel_shifter_right_pipe_if
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [CNT_W-1:0] in_cnt;
   logic [1:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, in_cnt, in_op, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_cnt, in_op, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/barrel_shifter_right_pipe_shr_stage.sv
// One registered stage of the right shifter: conditionally shifts by 2^K using
// the op-selected fill, and carries valid/op/remaining count/sign downstream.
module shr_stage
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W,
   parameter int K     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,      // stage empty or advancing this cycle
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic [CNT_W-1:0] up_cnt,
   input  logic [1:0]       up_op,
   input  logic             up_sign,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] cnt,
   output logic [1:0]       op,
   output logic             sign
);
   localparam int SH = 1 << K;
   localparam logic [CNT_W-1:0] CNT_MASK = ~(CNT_W'(1) << K);

   logic [SH-1:0]    fill;
   logic [WIDTH-1:0] shifted;

   // Fill bits entering from the top: rotated-out bits, zeros, or the captured sign.
   always_comb begin
      fill = '0;
      case (up_op)
         OP_ROR:  fill = up_data[SH-1:0];
         OP_SRA:  fill = {SH{up_sign}};
         default: fill = '0;
      endcase
      shifted = up_cnt[K] ? {fill, up_data[WIDTH-1:SH]} : up_data;
   end

   // Stage register: loads whenever the downstream slot frees up; consumed count bit is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         cnt   <= '0;
         op    <= '0;
         sign  <= 1'b0;
      end else if (load) begin
         valid <= up_valid;
         data  <= shifted;
         cnt   <= up_cnt & CNT_MASK;
         op    <= up_op;
         sign  <= up_sign;
      end
   end
endmodule

// File: rtl/barrel_shifter_right_pipe.sv
// Pipelined right rotate / logical / arithmetic shifter, one stage per count
// bit, with valid/ready flow control and bubble collapsing.
module barrel_shifter_right_pipe
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   barrel_shifter_right_pipe_if.slave  bus
);
   // Index 0 is the input side; index k+1 is the register of stage k.
   logic [CNT_W:0]            vld_pipe;
   logic [CNT_W:0]            rdy_pipe;
   logic [CNT_W:0]            sign_p;
   logic [CNT_W:0][WIDTH-1:0] data_p;
   logic [CNT_W:0][CNT_W-1:0] cnt_p;
   logic [CNT_W:0][1:0]       op_p;
   logic                      unused_tail;

   // S0 entry: pass forces a zero count; sign is sampled once from the operand.
   assign vld_pipe[0] = bus.in_valid;
   assign data_p[0]   = bus.in_data;
   assign cnt_p[0]    = (bus.in_op == OP_PASS) ? '0 : bus.in_cnt;
   assign op_p[0]     = bus.in_op;
   assign sign_p[0]   = bus.in_data[WIDTH-1];

   // Advance chain: stage k may load if the next slot is empty or itself advancing.
   always_comb begin
      rdy_pipe        = '0;
      rdy_pipe[CNT_W] = bus.out_ready;
      for (int k = CNT_W - 1; k >= 0; k--)
         rdy_pipe[k] = rdy_pipe[k+1] || !vld_pipe[k+1];
   end

   for (genvar k = 0; k < CNT_W; k++) begin : g_stage
      shr_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W), .K(k)) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (rdy_pipe[k]),
         .up_valid (vld_pipe[k]),
         .up_data  (data_p[k]),
         .up_cnt   (cnt_p[k]),
         .up_op    (op_p[k]),
         .up_sign  (sign_p[k]),
         .valid    (vld_pipe[k+1]),
         .data     (data_p[k+1]),
         .cnt      (cnt_p[k+1]),
         .op       (op_p[k+1]),
         .sign     (sign_p[k+1])
      );
   end

   assign bus.in_ready  = rdy_pipe[0];
   assign bus.out_valid = vld_pipe[CNT_W];
   assign bus.out_data  = data_p[CNT_W];

   // Last-stage side-band fields have no consumer.
   assign unused_tail = ^{cnt_p[CNT_W], op_p[CNT_W], sign_p[CNT_W]};
endmodule

// File: tb/tb_barrel_shifter_right_pipe.sv
// Self-checking bench for barrel_shifter_right_pipe: directed vector table,
// streaming, backpressure, async reset mid-flight and a randomized scoreboard.
module tb_barrel_shifter_right_pipe;
   localparam int W = 16;
   localparam int C = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   barrel_shifter_right_pipe_if #(.WIDTH(W), .CNT_W(C)) bus ();

   barrel_shifter_right_pipe #(.WIDTH(W), .CNT_W(C)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [W-1:0] d;
      logic [C-1:0] c;
      logic [1:0]   o;
      logic [W-1:0] e;
   } vec_t;

   typedef struct {
      logic [W-1:0] e;
      int           t;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0, n_fail = 0;
   int   cyc = 0, n_drain = 0;
   bit   chk_lat = 0, chk_rdy = 0;
   bit   prev_stall = 0;
   logic [W-1:0] prev_data = '0;
   logic last_in_ready;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: rotate via a doubled word, shifts via plain operators.
   function automatic logic [W-1:0] model(input logic [W-1:0] d, input int c, input logic [1:0] o);
      logic [2*W-1:0] dd;
      case (o)
         2'b00: begin dd = {d, d} >> c; return dd[W-1:0]; end
         2'b01: return d >> c;
         2'b10: return W'($signed(d) >>> c);
         default: return d;
      endcase
   endfunction

   // One clock cycle: drive on the falling edge, sample 1ns later, score the result.
   task automatic cycle(input logic iv, input logic [W-1:0] d, input logic [C-1:0] c,
                        input logic [1:0] o, input logic ordy, input logic [W-1:0] e,
                        output logic acc);
      exp_t x;
      @(negedge clk);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.in_cnt    = c;
      bus.in_op     = o;
      bus.out_ready = ordy;
      #1;
      last_in_ready = bus.in_ready;
      acc = iv && bus.in_ready;
      if (chk_rdy) chk("in_ready_high", bus.in_ready, 1);
      if (prev_stall) begin
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
         n_drain++;
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            x = exp_q.pop_front();
            chk("out_data", bus.out_data, x.e);
            if (chk_lat) chk("latency", cyc - x.t, 4);
         end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (acc) exp_q.push_back('{e, cyc});
      cyc++;
   endtask

   task automatic send(input logic [W-1:0] d, input logic [C-1:0] c, input logic [1:0] o,
                       input logic [W-1:0] e);
      logic acc;
      int   n;
      n = 0;
      do begin
         cycle(1, d, c, o, 1, e, acc);
         n++;
      end while (!acc && n < 50);
      if (!acc) chk("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      logic acc;
      int   n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         cycle(0, '0, '0, '0, 1, '0, acc);
         n++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   vec_t tbl[10];
   logic [W-1:0] stream_exp[8];

   initial begin
      logic acc;
      int   d0, acc_cnt, n;
      logic [W-1:0] bp_d[6];
      logic [C-1:0] bp_c[6];
      logic [1:0]   bp_o[6];
      logic [W-1:0] rd;
      logic [C-1:0] rc;
      logic [1:0]   ro;
      logic         riv, rordy;

      tbl[0] = '{16'h8001, 4'd1,  2'b00, 16'hC000};
      tbl[1] = '{16'h8000, 4'd15, 2'b10, 16'hFFFF};
      tbl[2] = '{16'h8000, 4'd15, 2'b01, 16'h0001};
      tbl[3] = '{16'h1234, 4'd4,  2'b10, 16'h0123};
      tbl[4] = '{16'hABCD, 4'd7,  2'b11, 16'hABCD};
      tbl[5] = '{16'h0001, 4'd15, 2'b00, 16'h0002};
      tbl[6] = '{16'hF00F, 4'd0,  2'b10, 16'hF00F};
      tbl[7] = '{16'hF00F, 4'd0,  2'b00, 16'hF00F};
      tbl[8] = '{16'hF00F, 4'd0,  2'b01, 16'hF00F};
      tbl[9] = '{16'h7FF0, 4'd8,  2'b10, 16'h007F};
      stream_exp = '{16'h00F0, 16'h0078, 16'h003C, 16'h001E,
                     16'h000F, 16'h8007, 16'hC003, 16'hE001};

      bus.in_valid = 0; bus.in_data = '0; bus.in_cnt = '0; bus.in_op = '0; bus.out_ready = 0;
      #12;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      #6 rst_n = 1;

      // Directed vectors, one at a time, latency and in_ready checked.
      chk_lat = 1;
      chk_rdy = 1;
      for (int i = 0; i < 10; i++) begin
         send(tbl[i].d, tbl[i].c, tbl[i].o, tbl[i].e);
         drain();
      end

      // Streaming: back-to-back accepts, results one per cycle.
      for (int i = 0; i < 8; i++) begin
         cycle(1, 16'h00F0, C'(i), 2'b00, 1, stream_exp[i], acc);
         chk("stream_accept", acc, 1);
      end
      drain();
      chk_rdy = 0;

      // Backpressure: downstream stalls, pipeline fills with exactly 4.
      chk_lat = 0;
      for (int i = 0; i < 6; i++) begin
         bp_d[i] = W'($urandom);
         bp_c[i] = C'($urandom);
         bp_o[i] = 2'($urandom);
      end
      acc_cnt = 0;
      d0 = n_drain;
      for (int i = 0; i < 10; i++) begin
         cycle(1, bp_d[acc_cnt], bp_c[acc_cnt], bp_o[acc_cnt], 0,
               model(bp_d[acc_cnt], int'(bp_c[acc_cnt]), bp_o[acc_cnt]), acc);
         if (acc) acc_cnt++;
      end
      chk("bp_accepted", acc_cnt, 4);
      chk("bp_in_ready_low", last_in_ready, 0);
      chk("bp_no_emit", n_drain - d0, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_head_data", bus.out_data, model(bp_d[0], int'(bp_c[0]), bp_o[0]));
      n = 0;
      while (acc_cnt < 6 && n < 40) begin
         cycle(1, bp_d[acc_cnt], bp_c[acc_cnt], bp_o[acc_cnt], 1,
               model(bp_d[acc_cnt], int'(bp_c[acc_cnt]), bp_o[acc_cnt]), acc);
         if (acc) acc_cnt++;
         n++;
      end
      chk("bp_all_accepted", acc_cnt, 6);
      drain();
      chk("bp_emitted", n_drain - d0, 6);

      // Async reset with three ops in flight.
      chk_lat = 1;
      for (int i = 0; i < 3; i++) begin
         cycle(1, 16'h5A5A + 16'(i), C'(i + 1), 2'b00, 1, model(16'h5A5A + 16'(i), i + 1, 2'b00), acc);
         chk("rst_seq_accept", acc, 1);
      end
      cycle(0, '0, '0, '0, 1, '0, acc);
      #5;
      chk("pre_rst_valid", bus.out_valid, 1);
      rst_n = 0;
      #1;
      chk("async_rst_valid", bus.out_valid, 0);
      chk("async_rst_data", bus.out_data, 0);
      chk("async_rst_ready", bus.in_ready, 1);
      #2 rst_n = 1;
      exp_q.delete();
      prev_stall = 0;
      d0 = n_drain;
      for (int i = 0; i < 8; i++) cycle(0, '0, '0, '0, 1, '0, acc);
      chk("post_rst_no_emit", n_drain - d0, 0);
      send(16'h8421, 4'd3, 2'b10, 16'hF084);
      drain();

      // Randomized traffic against the reference model.
      chk_lat = 0;
      acc_cnt = 0;
      n = 0;
      rd = W'($urandom); rc = C'($urandom); ro = 2'($urandom);
      while (acc_cnt < 10000 && n < 60000) begin
         riv   = ($urandom_range(0, 3) != 0);
         rordy = ($urandom_range(0, 3) != 0);
         cycle(riv, rd, rc, ro, rordy, model(rd, int'(rc), ro), acc);
         if (acc) begin
            acc_cnt++;
            rd = W'($urandom); rc = C'($urandom); ro = 2'($urandom);
         end
         n++;
      end
      chk("rand_accepted", acc_cnt, 10000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
